// File: rtl/movimentacao_servo.sv
// movimentacao_servo: triangular sweep sequencer for the 3-bit servo position.
// While ligar is high the position walks 0 -> POS_MAX -> 0 -> ... and holds
// each value for DWELL_CYCLES+1 clocks. A one-cycle passo pulse marks every
// new position so that downstream measurement logic can trigger once per step.
// Dropping ligar parks the servo at 0. Re-enabling restarts the sweep going up.
module movimentacao_servo #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int POS_MAX      = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  output logic [2:0] posicao,
  output logic       passo,
  output logic       sentido,
  output logic [1:0] db_estado
);

  // The dwell counter only has to reach DWELL_CYCLES-1.
  localparam int             CW        = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0]  C_TERM    = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0]  C_UM      = CW'(1);
  localparam logic [2:0]     C_POS_MAX = 3'(POS_MAX);

  // The encoding is visible on db_estado, so the codes are fixed explicitly.
  typedef enum logic [1:0] {
    INICIAL  = 2'b00,
    ESPERA   = 2'b01,
    MOVE     = 2'b10,
    INVALIDO = 2'b11
  } estado_t;

  estado_t       r_estado;
  estado_t       w_estado_next;
  logic [CW-1:0] r_contador;
  logic [CW-1:0] w_contador_next;
  logic [2:0]    r_posicao;
  logic [2:0]    w_posicao_next;
  logic          r_sentido;
  logic          w_sentido_next;
  logic          r_passo;
  logic          w_passo_next;

  // Candidate step of the sweep; it is only committed in MOVE.
  logic [2:0]    w_pos_prox;
  logic          w_sen_prox;

  // Next-position rule: endpoints are visited exactly once per turn and the
  // position never wraps modulo 8.
  always_comb begin
    w_pos_prox = r_posicao;
    w_sen_prox = r_sentido;
    if (r_sentido) begin
      if (r_posicao < C_POS_MAX) begin
        w_pos_prox = r_posicao + 3'd1;
      end else begin
        w_pos_prox = r_posicao - 3'd1;
        w_sen_prox = 1'b0;
      end
    end else begin
      if (r_posicao != 3'd0) begin
        w_pos_prox = r_posicao - 3'd1;
      end else begin
        w_pos_prox = 3'd1;
        w_sen_prox = 1'b1;
      end
    end
  end

  // FSM next-state and datapath next values; entering INICIAL always parks
  // the servo and re-arms the sweep upward.
  always_comb begin
    w_estado_next   = r_estado;
    w_contador_next = r_contador;
    w_posicao_next  = r_posicao;
    w_sentido_next  = r_sentido;
    w_passo_next    = 1'b0;

    case (r_estado)
      INICIAL: begin
        w_contador_next = '0;
        w_posicao_next  = 3'd0;
        w_sentido_next  = 1'b1;
        if (ligar) begin
          w_estado_next = ESPERA;
        end
      end

      ESPERA: begin
        // Losing the enable wins over the terminal count.
        if (!ligar) begin
          w_estado_next   = INICIAL;
          w_contador_next = '0;
          w_posicao_next  = 3'd0;
          w_sentido_next  = 1'b1;
        end else if (r_contador == C_TERM) begin
          w_estado_next   = MOVE;
          w_contador_next = '0;
        end else begin
          w_contador_next = r_contador + C_UM;
        end
      end

      MOVE: begin
        if (ligar) begin
          w_estado_next   = ESPERA;
          w_contador_next = '0;
          w_posicao_next  = w_pos_prox;
          w_sentido_next  = w_sen_prox;
          w_passo_next    = 1'b1;
        end else begin
          w_estado_next   = INICIAL;
          w_contador_next = '0;
          w_posicao_next  = 3'd0;
          w_sentido_next  = 1'b1;
        end
      end

      default: begin
        // Unused code: recover to the parked state on the next edge.
        w_estado_next   = INICIAL;
        w_contador_next = '0;
        w_posicao_next  = 3'd0;
        w_sentido_next  = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_estado_next;
    end
  end

  // Registered datapath: dwell counter, position, direction and step pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_contador <= '0;
      r_posicao  <= 3'd0;
      r_sentido  <= 1'b1;
      r_passo    <= 1'b0;
    end else begin
      r_contador <= w_contador_next;
      r_posicao  <= w_posicao_next;
      r_sentido  <= w_sentido_next;
      r_passo    <= w_passo_next;
    end
  end

  assign posicao   = r_posicao;
  assign sentido   = r_sentido;
  assign passo     = r_passo;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_movimentacao_servo.sv
// Scoreboard bench for movimentacao_servo. Stimulus pushes the expected
// (posicao, sentido, cycle) of every step pulse into a queue; per-DUT monitors
// pop and compare whenever passo is seen. Two instances cover the full
// 0..7 sweep and the minimal POS_MAX=1 range.
module tb_movimentacao_servo;

  typedef struct {
    logic [2:0] pos;
    logic       sen;
    int         t;
  } exp_t;

  logic       clk;
  logic       rst_a, ligar_a, rst_b, ligar_b;
  logic [2:0] pos_a, pos_b;
  logic       passo_a, passo_b, sen_a, sen_b;
  logic [1:0] db_a, db_b;

  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t q_a[$];
  exp_t q_b[$];
  logic prev_a, prev_b;

  int pos_tab[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int sen_tab[15] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};

  movimentacao_servo #(.DWELL_CYCLES(4), .POS_MAX(7)) dut_a (
    .clock(clk), .reset(rst_a), .ligar(ligar_a),
    .posicao(pos_a), .passo(passo_a), .sentido(sen_a), .db_estado(db_a)
  );

  movimentacao_servo #(.DWELL_CYCLES(2), .POS_MAX(1)) dut_b (
    .clock(clk), .reset(rst_b), .ligar(ligar_b),
    .posicao(pos_b), .passo(passo_b), .sentido(sen_b), .db_estado(db_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor for the 0..7 instance.
  always @(negedge clk) begin
    if (passo_a) begin
      chk("a_passo_width", {31'd0, prev_a}, 32'd0);
      if (q_a.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL a_unexpected_passo: got pulse pos=%0d, expected none (cycle %0d)", pos_a, cyc);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        $display("a step: pos=%0d sentido=%0d cycle=%0d", pos_a, sen_a, cyc);
        chk("a_pos", {29'd0, pos_a}, {29'd0, e.pos});
        chk("a_sentido", {31'd0, sen_a}, {31'd0, e.sen});
        chk("a_time", cyc, e.t);
      end
    end
    prev_a = passo_a;
  end

  // Monitor for the POS_MAX=1 instance.
  always @(negedge clk) begin
    if (passo_b) begin
      chk("b_passo_width", {31'd0, prev_b}, 32'd0);
      if (q_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected_passo: got pulse pos=%0d, expected none (cycle %0d)", pos_b, cyc);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        $display("b step: pos=%0d sentido=%0d cycle=%0d", pos_b, sen_b, cyc);
        chk("b_pos", {29'd0, pos_b}, {29'd0, e.pos});
        chk("b_sentido", {31'd0, sen_b}, {31'd0, e.sen});
        chk("b_time", cyc, e.t);
      end
    end
    prev_b = passo_b;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, t2, t3, tb0;
    cyc = 0; n_vec = 0; n_err = 0; prev_a = 1'b0; prev_b = 1'b0;
    rst_a = 1'b1; ligar_a = 1'b0; rst_b = 1'b1; ligar_b = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_pos", {29'd0, pos_a}, 32'd0);
    chk("rst_sentido", {31'd0, sen_a}, 32'd1);
    chk("rst_passo", {31'd0, passo_a}, 32'd0);
    chk("rst_db", {30'd0, db_a}, 32'd0);
    chk("rst_b_pos", {29'd0, pos_b}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);

    // Full sweep: 15 pulses, 5 cycles apart, first at t0+5
    ligar_a = 1'b1;
    t0 = cyc + 1;
    for (int k = 0; k < 15; k++)
      q_a.push_back('{pos: 3'(pos_tab[k]), sen: 1'(sen_tab[k]), t: t0 + 5 * (k + 1)});
    wait_cyc(t0 + 1);
    chk("espera_db", {30'd0, db_a}, 32'd1);
    wait_cyc(t0 + 76);
    ligar_a = 1'b0;
    wait_cyc(t0 + 78);
    chk("sweep_off_db", {30'd0, db_a}, 32'd0);
    chk("sweep_off_pos", {29'd0, pos_a}, 32'd0);
    chk("sweep_off_sentido", {31'd0, sen_a}, 32'd1);
    chk("sweep_queue_empty", q_a.size(), 32'd0);

    // Disable mid-dwell at posicao=5, counter=2
    ligar_a = 1'b1;
    t1 = cyc + 1;
    for (int k = 0; k < 5; k++)
      q_a.push_back('{pos: 3'(k + 1), sen: 1'b1, t: t1 + 5 * (k + 1)});
    wait_cyc(t1 + 27);
    chk("middwell_pos_before", {29'd0, pos_a}, 32'd5);
    ligar_a = 1'b0;
    wait_cyc(t1 + 28);
    chk("middwell_pos", {29'd0, pos_a}, 32'd0);
    chk("middwell_sentido", {31'd0, sen_a}, 32'd1);
    chk("middwell_db", {30'd0, db_a}, 32'd0);
    chk("middwell_passo", {31'd0, passo_a}, 32'd0);
    chk("middwell_queue_empty", q_a.size(), 32'd0);

    // Re-enable, then drop ligar during the single MOVE cycle
    ligar_a = 1'b1;
    t2 = cyc + 1;
    q_a.push_back('{pos: 3'd1, sen: 1'b1, t: t2 + 5});
    wait_cyc(t2 + 9);
    chk("move_db", {30'd0, db_a}, 32'd2);
    chk("move_pos_before", {29'd0, pos_a}, 32'd1);
    ligar_a = 1'b0;
    wait_cyc(t2 + 10);
    chk("move_off_db", {30'd0, db_a}, 32'd0);
    chk("move_off_passo", {31'd0, passo_a}, 32'd0);
    chk("move_off_pos", {29'd0, pos_a}, 32'd0);
    wait_cyc(t2 + 20);
    chk("move_queue_empty", q_a.size(), 32'd0);

    // Async reset during MOVE at posicao=7, sentido=1
    ligar_a = 1'b1;
    t3 = cyc + 1;
    for (int k = 0; k < 7; k++)
      q_a.push_back('{pos: 3'(k + 1), sen: 1'b1, t: t3 + 5 * (k + 1)});
    wait_cyc(t3 + 39);
    chk("rmove_db", {30'd0, db_a}, 32'd2);
    chk("rmove_pos_before", {29'd0, pos_a}, 32'd7);
    #2 rst_a = 1'b1;
    #1;
    chk("rmove_pos", {29'd0, pos_a}, 32'd0);
    chk("rmove_sentido", {31'd0, sen_a}, 32'd1);
    chk("rmove_passo", {31'd0, passo_a}, 32'd0);
    chk("rmove_db", {30'd0, db_a}, 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    ligar_a = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_quiet", {28'd0, passo_a, pos_a}, 32'd0);
    end
    chk("rmove_queue_empty", q_a.size(), 32'd0);

    // POS_MAX=1, DWELL_CYCLES=2: alternating 1,0 every 3 cycles
    @(negedge clk);
    ligar_b = 1'b1;
    tb0 = cyc + 1;
    for (int k = 1; k <= 8; k++)
      q_b.push_back('{pos: (k % 2 == 1) ? 3'd1 : 3'd0, sen: (k % 2 == 1), t: tb0 + 3 * k});
    wait_cyc(tb0 + 25);
    ligar_b = 1'b0;
    wait_cyc(tb0 + 30);
    chk("b_queue_empty", q_b.size(), 32'd0);
    chk("b_off_pos", {29'd0, pos_b}, 32'd0);
    chk("b_off_db", {30'd0, db_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/movimentacao_servo.md
Name: movimentacao_servo

Overview:
Upstream position sequencer for the servo control path. While enabled, it sweeps a 3-bit servo position triangularly (0→POS_MAX→0→…), holding each position for a fixed dwell time. The block drives the 3-bit position input of the servo controller/PWM stage. It also emits a one-cycle step pulse on each position change, so downstream measurement logic can trigger once per position.

Parameters:
DWELL_CYCLES, 50_000_000, clock cycles spent counting at each position (legal range ≥2; 1 s at 50 MHz)
POS_MAX, 7, highest position in the sweep (legal range 1..7)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high; returns block to INICIAL immediately
ligar  input  1  sweep enable, synchronous level; 0 parks servo at position 0
posicao  output  3  current servo position, registered, feeds servo controller
passo  output  1  one-cycle pulse, high in the first cycle a new posicao is visible
sentido  output  1  sweep direction, registered; 1 = increasing, 0 = decreasing
db_estado  output  2  debug: current FSM state code

Behaviour:
- Reset (async, any time, including mid-dwell or during MOVE):
  - posicao=0, sentido=1, passo=0, dwell counter=0, state=INICIAL, db_estado=00.
  - No pulse is generated on reset release.
- FSM states:
  - INICIAL (00): posicao held at 0, sentido=1, counter=0. If ligar=1 at an edge → ESPERA.
  - ESPERA (01): counter increments by 1 per clock.
    - When counter==DWELL_CYCLES-1 at an edge → MOVE; counter cleared.
    - If ligar=0 at an edge → INICIAL; this takes priority over the terminal count.
  - MOVE (10): lasts exactly one cycle.
    - If ligar=1 at the edge: posicao←next, passo←1, counter←0, → ESPERA.
    - If ligar=0 at the edge: → INICIAL with no position update and no pulse.
  - Code 11 is unused; if reached, the FSM goes to INICIAL on the next edge.
- Leaving INICIAL or returning to it (ligar dropped):
  - On the edge that enters INICIAL: posicao←0, sentido←1, counter←0, passo←0.
  - Re-enabling always restarts the sweep from 0, going up.
- Next-position rule (registered, 3-bit, never wraps modulo 8):
  - sentido=1, posicao<POS_MAX: posicao+1.
  - sentido=1, posicao==POS_MAX: posicao-1, sentido←0.
  - sentido=0, posicao>0: posicao-1.
  - sentido=0, posicao==0: 1, sentido←1.
  - Endpoints are visited once per turn, so with POS_MAX=7 the period is 14 steps: 0,1..7,6..1,0,1…
- Timing:
  - First ESPERA cycle follows the edge that samples ligar=1.
  - First passo occurs exactly DWELL_CYCLES+1 cycles after that edge.
  - Consecutive passo pulses are exactly DWELL_CYCLES+1 cycles apart.
- passo is high for exactly one cycle, coincident with the first cycle of the new posicao. It is never high in INICIAL.
- Counter width: $clog2(DWELL_CYCLES). The counter never exceeds DWELL_CYCLES-1.
- All outputs are registered; there is no combinational path from ligar to any output.

Test Plan:
- Reset/idle: assert reset mid-simulation with ligar=1 → same cycle posicao=0, sentido=1, passo=0, db_estado=00; hold ligar=0 for 100 cycles → no passo, posicao stays 0.
- Full sweep, DWELL_CYCLES=4, POS_MAX=7:
  - Stimulus: ligar=1 sampled at edge t0.
  - First passo at t0+5 with posicao=1.
  - Pulses every 5 cycles: posicao sequence 1,2,…,7,6,…,0,1.
  - sentido falls when posicao becomes 6 after 7, and rises when posicao becomes 1 after 0.
  - 14 pulses per full period.
- Disable mid-dwell: ligar=0 while posicao=5, counter=2 → next edge posicao=0, sentido=1, db_estado=00, no passo; re-enable → first passo after DWELL_CYCLES+1 cycles with posicao=1.
- Disable in MOVE: drop ligar in the single MOVE cycle → no posicao update, no passo, INICIAL on that edge.
- Async reset during MOVE at posicao=7, sentido=1 → immediate posicao=0, no passo on reset release.
- Small range POS_MAX=1, DWELL_CYCLES=2 → posicao alternates 1,0,1,0 with passo every 3 cycles; passo never lasts more than one cycle.
